// File: rtl/window_serializer.sv
// Purpose : turns one parallel KERNEL_SIZE x KERNEL_SIZE window into a serial element stream.
// Latency : first element on the cycle after the load edge; N cycles per window at full rate.
// Backpr. : out_ready=0 freezes idx/serial_out/last, write_en stays high; a new window is
//           accepted in IDLE or on the final transfer, so windows run back-to-back without gaps.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   load       upstream valid; window_in captured on load && load_ready
//   window_in  flattened window, element j at [BITS*j +: BITS]
//   load_ready block can accept a window this cycle (combinational from out_ready)
//   out_ready  downstream accepts serial_out this cycle
//   write_en   serial_out valid
//   serial_out current element
//   last       high while element N-1 is presented
//   done       one-cycle pulse after element N-1 transfers
module window_serializer #(
    parameter int BITS        = 9,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window_in,
    output logic                                load_ready,
    input  logic                                out_ready,
    output logic                                write_en,
    output logic [BITS-1:0]                     serial_out,
    output logic                                last,
    output logic                                done
);

    localparam int N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [BITS-1:0]  r_buf [N];
    logic             r_done;

    logic             w_last;
    logic             w_xfer;
    logic             w_end;
    logic             w_capture;

    // Handshake terms shared by the FSM and the datapath.
    always_comb begin
        w_last     = (r_state == SHIFT) && (r_idx == LAST_IDX);
        w_xfer     = (r_state == SHIFT) && out_ready;
        w_end      = w_xfer && w_last;
        // Gated by reset so the block reports not-ready while held in reset,
        // even though the state register already reads IDLE.
        load_ready = reset && ((r_state == IDLE) || (w_last && out_ready));
        w_capture  = load && load_ready;
    end

    // Next-state / index logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_nxt = SHIFT;
                    w_idx_nxt   = '0;
                end
            end
            SHIFT: begin
                if (w_end) begin
                    // Final element leaves: either chain straight into the
                    // next window or fall back to IDLE.
                    w_idx_nxt   = '0;
                    w_state_nxt = w_capture ? SHIFT : IDLE;
                end else if (w_xfer) begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_end;
        end
    end

    // Window buffer: only written on an accepted load, so a load while busy
    // leaves the window being streamed untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < N; j++) begin
                r_buf[j] <= '0;
            end
        end else if (w_capture) begin
            for (int j = 0; j < N; j++) begin
                r_buf[j] <= window_in[BITS*j +: BITS];
            end
        end
    end

    always_comb begin
        write_en   = (r_state == SHIFT);
        serial_out = (r_state == SHIFT) ? r_buf[r_idx] : '0;
        last       = w_last;
        done       = r_done;
    end

endmodule

// File: tb/tb_window_serializer.sv
// Directed bench for window_serializer: reset, single window, backpressure,
// back-to-back windows, ignored load while busy, and reset mid-window.
module tb_window_serializer;

    localparam int BITS = 9;
    localparam int K    = 3;
    localparam int N    = K * K;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  load = 1'b0;
    logic                  out_ready = 1'b0;
    logic [N*BITS-1:0]     window_in = '0;
    logic                  load_ready;
    logic                  write_en;
    logic [BITS-1:0]       serial_out;
    logic                  last;
    logic                  done;

    window_serializer #(.BITS(BITS), .KERNEL_SIZE(K)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .window_in  (window_in),
        .load_ready (load_ready),
        .out_ready  (out_ready),
        .write_en   (write_en),
        .serial_out (serial_out),
        .last       (last),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Transfer monitor: samples on the falling edge, away from the active edge.
    int             cyc = 0;
    int             xq[$];
    int             lq[$];
    int             cq[$];
    int             dq[$];
    int             hold_err = 0;
    logic           p_stall = 1'b0;
    logic [BITS-1:0] p_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (p_stall && (!write_en || serial_out !== p_val)) hold_err++;
            if (write_en && out_ready) begin
                xq.push_back(int'(serial_out));
                lq.push_back(int'(last));
                cq.push_back(cyc);
            end
            if (done) dq.push_back(cyc);
            p_stall = write_en && !out_ready;
            p_val   = serial_out;
        end else begin
            p_stall = 1'b0;
        end
    end

    task automatic clear_mon();
        xq.delete(); lq.delete(); cq.delete(); dq.delete();
        hold_err = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input int base);
        for (int j = 0; j < N; j++) window_in[BITS*j +: BITS] = BITS'(base + j);
    endtask

    // Expected stream: window 0 elements base0+j, then window 1 elements base1+j.
    task automatic check_stream(input string t, input int base0, input int base1,
                                input int nwin, input bit contig);
        int exp_v;
        chk($sformatf("%s_count", t), xq.size(), nwin * N);
        for (int p = 0; p < xq.size() && p < nwin * N; p++) begin
            exp_v = (p < N) ? base0 + p : base1 + p - N;
            chk($sformatf("%s_val%0d", t, p), xq[p], exp_v);
            chk($sformatf("%s_last%0d", t, p), lq[p], ((p % N) == N - 1) ? 1 : 0);
            if (contig && p > 0) chk($sformatf("%s_gap%0d", t, p), cq[p] - cq[p-1], 1);
        end
        chk($sformatf("%s_done_cnt", t), dq.size(), nwin);
        for (int w = 0; w < nwin && w < dq.size(); w++) begin
            if (w * N + N - 1 < cq.size())
                chk($sformatf("%s_done_time%0d", t, w), dq[w] - cq[w*N+N-1], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_we", write_en, 0);
        chk("rst_out", serial_out, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 0);
        chk("rst_lr", load_ready, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_lr", load_ready, 1);
        chk("rel_we", write_en, 0);
        chk("rel_out", serial_out, 0);

        // Single window at full rate
        tick(); clear_mon(); set_win(10); load = 1'b1; out_ready = 1'b1;
        tick(); load = 1'b0;
        @(negedge clk);
        chk("t2_first_we", write_en, 1);
        chk("t2_first_val", serial_out, 10);
        repeat (12) tick();
        @(negedge clk);
        chk("t2_idle_we", write_en, 0);
        chk("t2_idle_lr", load_ready, 1);
        check_stream("t2", 10, 0, 1, 1'b1);

        // Backpressure 1,0,0,1,...
        tick(); clear_mon(); set_win(10); load = 1'b1; out_ready = 1'b1;
        tick(); load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            out_ready = pat[k % 4];
            tick();
        end
        out_ready = 1'b1;
        check_stream("t3", 10, 0, 1, 1'b0);
        chk("t3_hold", hold_err, 0);

        // Back-to-back windows
        tick(); clear_mon(); set_win(10); load = 1'b1; out_ready = 1'b1;
        tick(); load = 1'b0;
        repeat (8) tick();
        set_win(100); load = 1'b1;
        #1;
        chk("t4_last", last, 1);
        chk("t4_lr", load_ready, 1);
        tick(); load = 1'b0;
        repeat (14) tick();
        check_stream("t4", 10, 100, 2, 1'b1);

        // Load while busy is ignored
        tick(); clear_mon(); set_win(10); load = 1'b1; out_ready = 1'b1;
        tick(); load = 1'b0;
        repeat (3) tick();
        set_win(50); load = 1'b1;
        #1;
        chk("t5_lr_busy", load_ready, 0);
        repeat (2) tick();
        load = 1'b0;
        repeat (10) tick();
        check_stream("t5", 10, 0, 1, 1'b1);
        @(negedge clk);
        chk("t5_idle_we", write_en, 0);

        // Reset mid-window
        tick(); clear_mon(); set_win(10); load = 1'b1; out_ready = 1'b1;
        tick(); load = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        chk("t6_we", write_en, 0);
        chk("t6_out", serial_out, 0);
        chk("t6_last", last, 0);
        chk("t6_lr", load_ready, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("t6_xfers", xq.size(), 4);
        chk("t6_no_done", dq.size(), 0);
        @(posedge clk); #1 reset = 1'b1;
        clear_mon(); set_win(10); load = 1'b1;
        tick(); load = 1'b0;
        repeat (11) tick();
        check_stream("t6b", 10, 0, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/window_serializer.md
Name: window_serializer

Overview:
- Inverse of the pixel-stream-to-window shift register. It accepts one flattened KERNEL_SIZE x KERNEL_SIZE window of BITS-wide elements in parallel and emits the elements serially, one per accepted cycle.
- The serial side uses the same write_en / data convention as the stream input of the shift register, extended with backpressure (out_ready).
- Used to stream windows and conv tiles back out of the accelerator, and as a stimulus source for the shift register.

Parameters:
- BITS, 9, width of one element.
- KERNEL_SIZE, 3, window edge; N = KERNEL_SIZE*KERNEL_SIZE elements per window.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  upstream valid; window_in is captured when load && load_ready.
- window_in  in  KERNEL_SIZE*KERNEL_SIZE*BITS  flattened window; element j = window_in[BITS*j +: BITS].
- load_ready  out  1  block can accept a window this cycle.
- out_ready  in  1  downstream accepts serial_out this cycle.
- write_en  out  1  serial_out valid.
- serial_out  out  BITS  current element.
- last  out  1  high while element N-1 is presented.
- done  out  1  one-cycle pulse after element N-1 transfers.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, idx=0, buffer cleared.
  - Outputs while in reset: write_en=0, serial_out=0, last=0, done=0, load_ready=0.
  - After release: load_ready=1 (IDLE).
- State IDLE:
  - load_ready=1, write_en=0, serial_out=0.
  - On load: register all N elements, idx<=0, go to SHIFT.
- State SHIFT:
  - write_en=1, serial_out=buffer[idx], last=(idx==N-1).
  - A transfer is write_en && out_ready.
  - On transfer with idx<N-1: idx<=idx+1.
  - On transfer with idx==N-1: done<=1 on the next cycle.
    - If load is also high this cycle: capture the new window, idx<=0, stay in SHIFT.
    - Otherwise: go to IDLE.
- load_ready = IDLE || (SHIFT && last && out_ready). This is combinational from out_ready and enables zero-bubble back-to-back windows.
- Backpressure: while out_ready=0, idx, serial_out and last hold stable; write_en stays 1 and is never withdrawn once raised.
- load while load_ready=0 is ignored; the buffer is unchanged.
- Latency:
  - First element is valid the cycle after the load edge.
  - With out_ready held high, a window occupies exactly N cycles.
  - done is asserted in cycle N+1 after load.
- idx width = clog2(N). No wrap beyond N-1; idx returns to 0 only on a new capture or IDLE entry.
- Reset asserted mid-window aborts immediately: remaining elements are discarded, no done pulse is produced, and the block returns to IDLE.

Test Plan:
- Reset check: pulse reset low, hold load=0 -> write_en=0, serial_out=0, done=0, load_ready=1 after release.
- Single window: window_in element j = 10+j, load for 1 cycle, out_ready=1 -> serial_out 10..18 on 9 consecutive cycles, last only on 18, done pulses once the next cycle, then load_ready=1.
- Backpressure: same window, toggle out_ready 1,0,0,1,... -> each value is held during stall cycles, no element is skipped or duplicated, 9 transfers total.
- Back-to-back: second window (element j = 100+j) loaded in the cycle where last && out_ready -> 18 contiguous transfers (10..18 then 100..108) with no gap and two done pulses.
- Ignored load: assert load with window element j = 50+j mid-window -> output sequence unaffected, no 50s appear.
- Mid-operation reset: reset low after the 4th transfer -> write_en=0 immediately, no done pulse. A new load then streams from element 0.
